// File: rtl/s_axi_lite.sv
// s_axi_lite: AXI4-Lite responder over a small register file with a write-strobe export
module s_axi_lite #(
    parameter int DWIDTH    = 32,
    parameter int REG_WIDTH = 5,
    parameter int NREG      = 4,
    localparam int IW       = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int SW       = DWIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [REG_WIDTH-1:0]   awaddr,
    input  logic [2:0]             awprot,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [DWIDTH-1:0]      wdata,
    input  logic [SW-1:0]          wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [REG_WIDTH-1:0]   araddr,
    input  logic [2:0]             arprot,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [DWIDTH-1:0]      rdata,
    output logic [1:0]             rresp,
    output logic [NREG*DWIDTH-1:0] regs,
    output logic                   wr_strobe,
    output logic [IW-1:0]          wr_idx
);
    logic [DWIDTH-1:0]    mem [NREG];
    logic                 aw_held, w_held;
    logic [REG_WIDTH-3:0] aw_q;
    logic [DWIDTH-1:0]    w_q;
    logic [SW-1:0]        s_q;
    logic [REG_WIDTH-3:0] w_idx, r_idx;
    logic [DWIDTH-1:0]    w_dat;
    logic [SW-1:0]        w_stb;
    logic                 aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
    logic                 unused;

    assign unused  = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
    assign awready = !rst && !aw_held && !bvalid;
    assign wready  = !rst && !w_held && !bvalid;
    assign arready = !rst && !rvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    // Held values take priority; otherwise the channel is handshaking this cycle
    assign w_idx   = aw_held ? aw_q : awaddr[REG_WIDTH-1:2];
    assign w_dat   = w_held ? w_q : wdata;
    assign w_stb   = w_held ? s_q : wstrb;
    assign r_idx   = araddr[REG_WIDTH-1:2];
    assign w_ok    = int'(w_idx) < NREG;
    assign r_ok    = int'(r_idx) < NREG;
    assign commit  = (aw_hs || aw_held) && (w_hs || w_held) && !bvalid;

    for (genvar g = 0; g < NREG; g++) begin : g_regs
        assign regs[g*DWIDTH +: DWIDTH] = mem[g];
    end

    // Write path: hold AW/W independently, commit when both present, respond on B
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_q      <= '0;
            w_q       <= '0;
            s_q       <= '0;
            bvalid    <= 1'b0;
            bresp     <= 2'b00;
            wr_strobe <= 1'b0;
            wr_idx    <= '0;
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else begin
            wr_strobe <= commit && w_ok;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_q    <= awaddr[REG_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_q    <= wdata;
                s_q    <= wstrb;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= w_ok ? 2'b00 : 2'b10;
                if (w_ok) begin
                    wr_idx <= w_idx[IW-1:0];
                    for (int k = 0; k < SW; k++)
                        if (w_stb[k]) mem[w_idx[IW-1:0]][k*8 +: 8] <= w_dat[k*8 +: 8];
                end
            end
            if (bvalid && bready) begin
                bvalid  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Read path: register data/response at the AR handshake, hold until R completes
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= r_ok ? mem[r_idx[IW-1:0]] : '0;
            rresp  <= r_ok ? 2'b00 : 2'b10;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end
endmodule
